// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared states and framing constants for the word transmitter.
// Revision: 1.0
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        DONE  = 3'd4
    } tx_state_t;

    localparam logic START_BIT      = 1'b0;
    localparam logic STOP_BIT       = 1'b1;
    localparam int   BITS_PER_BYTE  = 8;
    localparam int   BITS_PER_FRAME = 10;

    // Index width that stays at least one bit wide for single-entry ranges.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_word_tx_if.sv
`default_nettype none
// ============================================================================
// Module  : uart_word_tx_if
// Brief   : Request/status bundle between control unit and word transmitter.
// Revision: 1.0
// ============================================================================
interface uart_word_tx_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  SerialOutEn;
    logic [DATA_WIDTH-1:0] Data;
    logic                  SerialOut;
    logic                  TX_flag;
    logic                  Busy;

    modport master (
        output SerialOutEn,
        output Data,
        input  SerialOut,
        input  TX_flag,
        input  Busy
    );

    modport slave (
        input  SerialOutEn,
        input  Data,
        output SerialOut,
        output TX_flag,
        output Busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_word_tx_baud_counter.sv
`default_nettype none
// ============================================================================
// Module  : baud_counter
// Brief   : Bit-period timer; ticks on the last cycle of each serial bit.
// Revision: 1.0
// ============================================================================
module baud_counter
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic clear,
    output logic      tick
);
    localparam int               CNT_W = idx_width(BAUD_DIV);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] count;

    assign tick = (count == LAST);

    always_ff @(posedge clk) begin
        if (reset || clear || tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/uart_word_tx.sv
`default_nettype none
// ============================================================================
// Module  : uart_word_tx
// Brief   : Sends a latched word as back-to-back 8N1 frames, LSB byte first.
// Revision: 1.0
// ============================================================================
module uart_word_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BAUD_DIV   = 434
) (
    input  wire logic       clk,
    input  wire logic       reset,
    uart_word_tx_if.slave   bus
);
    localparam int               NBYTES    = DATA_WIDTH / BITS_PER_BYTE;
    localparam int               BYTE_W    = idx_width(NBYTES);
    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NBYTES - 1);

    tx_state_t             state, state_next;
    logic [DATA_WIDTH-1:0] shift_word, shift_next;
    logic [BYTE_W-1:0]     byte_idx, byte_next;
    logic [2:0]            bit_idx, bit_next;
    logic                  serial_out, serial_next;
    logic                  tx_flag, flag_next;
    logic                  busy, busy_next;
    logic                  tick;
    logic                  clear;

    baud_counter #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud (
        .clk   (clk),
        .reset (reset),
        .clear (clear),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            shift_word <= '0;
            byte_idx   <= '0;
            bit_idx    <= '0;
            serial_out <= STOP_BIT;
            tx_flag    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            shift_word <= shift_next;
            byte_idx   <= byte_next;
            bit_idx    <= bit_next;
            serial_out <= serial_next;
            tx_flag    <= flag_next;
            busy       <= busy_next;
        end
    end

    always_comb begin
        state_next = state;
        shift_next = shift_word;
        byte_next  = byte_idx;
        bit_next   = bit_idx;

        case (state)
            IDLE: begin
                if (bus.SerialOutEn) begin
                    state_next = START;
                    shift_next = bus.Data;
                    byte_next  = '0;
                    bit_next   = '0;
                end
            end
            START: begin
                if (tick) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                        bit_next   = '0;
                    end else begin
                        bit_next   = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (byte_idx == LAST_BYTE) begin
                        state_next = DONE;
                    end else begin
                        // Next byte moves into the low lane; no idle gap.
                        state_next = START;
                        byte_next  = byte_idx + BYTE_W'(1);
                        shift_next = shift_word >> BITS_PER_BYTE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Outputs are registered from the upcoming state so they line up
        // with the state they describe.
        serial_next = STOP_BIT;
        case (state_next)
            START:   serial_next = START_BIT;
            DATA:    serial_next = shift_next[bit_next];
            default: serial_next = STOP_BIT;
        endcase

        flag_next = (state_next == DONE);
        busy_next = (state_next == START) || (state_next == DATA) ||
                    (state_next == STOP);

        // Every state entry restarts the bit period.
        clear = (state_next != state) || (state == IDLE);
    end

    assign bus.SerialOut = serial_out;
    assign bus.TX_flag   = tx_flag;
    assign bus.Busy      = busy;
endmodule
`default_nettype wire

// File: doc/uart_word_tx.md
# uart_word_tx

Serial transmitter downstream of the control unit's UART write-back states. When the control unit pulses `SerialOutEn`, it latches a `DATA_WIDTH`-bit word and sends it on `SerialOut` as consecutive 8N1 frames, least-significant byte first. At completion it pulses `TX_flag`, which releases the control unit from its wait state.

## Interface
- `DATA_WIDTH`, 32: word width; must be a multiple of 8; `NBYTES = DATA_WIDTH/8`.
- `BAUD_DIV`, 434: clock cycles per serial bit (50 MHz / 115200); must be ≥ 2.
- `clk`  input  1  system clock; all logic on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `SerialOutEn`  input  1  start request, sampled every cycle; acted on only in IDLE.
- `Data`  input  DATA_WIDTH  word to send; sampled in the same cycle `SerialOutEn` is accepted.
- `SerialOut`  output  1  serial line; registered; idles high.
- `TX_flag`  output  1  one-cycle done pulse after the last stop bit.
- `Busy`  output  1  high from acceptance until the cycle `TX_flag` asserts; registered.

## Operation
- Reset values: `SerialOut`=1, `TX_flag`=0, `Busy`=0, state IDLE, all counters 0. Reset takes priority over every other event, including mid-frame; the line returns high on the next edge.
- States:
  - IDLE: if `SerialOutEn`=1, load `Data` into the shift word, clear `byte_idx` and `bit_idx`, set `Busy`=1, go to START. Otherwise stay in IDLE.
  - START: drive `SerialOut`=0 for `BAUD_DIV` cycles, then go to DATA.
  - DATA: drive bit `bit_idx` of the current byte, LSB first. Hold each bit `BAUD_DIV` cycles. After bit 7, go to STOP.
  - STOP: drive `SerialOut`=1 for `BAUD_DIV` cycles.
    - If `byte_idx` < `NBYTES-1`: increment `byte_idx` and go directly to START. There is no idle gap between bytes.
    - Otherwise: go to DONE.
  - DONE: pulse `TX_flag`=1 for one cycle, clear `Busy`, keep `SerialOut`=1, go to IDLE.
- Baud timer:
  - Counts 0 to `BAUD_DIV-1`. Its terminal count advances the bit.
  - It is cleared on every state entry, so each bit lasts exactly `BAUD_DIV` cycles.
  - Counter width is `$clog2(BAUD_DIV)`.
- `SerialOutEn` asserted in any state other than IDLE is ignored; no queuing.
- `SerialOutEn` asserted in the DONE cycle is ignored. A new request is accepted only in IDLE, one cycle after `TX_flag`.
- Changes on `Data` after acceptance have no effect on the word in flight.

## Timing
- Acceptance edge = cycle 0. The start bit appears on `SerialOut` from cycle 1.
- Each byte occupies 10·`BAUD_DIV` cycles. The whole word occupies `NBYTES`·10·`BAUD_DIV` cycles, i.e. cycles 1 through `NBYTES`·10·`BAUD_DIV`.
- `TX_flag` is high for exactly one cycle, at cycle `NBYTES`·10·`BAUD_DIV`+1. `Busy` is low from that same cycle.
- Earliest next acceptance is at cycle `NBYTES`·10·`BAUD_DIV`+2.
- All outputs are registered: no combinational path from inputs to outputs.

## Structure
- Shared package `uart_pkg`:
  - state enumeration: IDLE, START, DATA, STOP, DONE
  - constants `START_BIT`=0, `STOP_BIT`=1, `BITS_PER_BYTE`=8, `BITS_PER_FRAME`=10
- One natural sub-module: `baud_counter`.
  - Inputs: `clk`, `reset`, `clear`.
  - Output: a `tick` on terminal count.
  - Parameter: `BAUD_DIV`.
- Byte select is a shift of the latched word by 8 on each STOP-to-START transition. No wide multiplexer.

## Test plan
- Reset idle, `BAUD_DIV`=4: hold `reset` 3 cycles, then idle 20 cycles → `SerialOut`=1, `TX_flag`=0, `Busy`=0 throughout.
- Single word, `BAUD_DIV`=4, `Data`=32'hA5C3_0F81:
  - line carries bytes 81, 0F, C3, A5, each framed 0-LSB…MSB-1, 40 cycles per byte
  - `TX_flag` pulses once, at cycle 161
- Ignored request: `SerialOutEn` re-pulsed with `Data`=32'hFFFF_FFFF at cycles 10 and 100 of the previous transfer → waveform identical to the single-word case; exactly one `TX_flag`.
- Back-to-back, `BAUD_DIV`=4, words 32'h0000_0000 then 32'hFFFF_FFFF:
  - second `SerialOutEn` issued the cycle after `TX_flag` → accepted, second start bit at cycle 163
  - 0xFF bytes show only the start bit low
- Reset mid-frame: assert `reset` during the DATA state of byte 2 → next cycle `SerialOut`=1, `Busy`=0, no `TX_flag`; a subsequent request transmits normally from byte 0.
- Parameter sweep: `DATA_WIDTH`=8 with `BAUD_DIV`=2, and `DATA_WIDTH`=16 with `BAUD_DIV`=5 → `TX_flag` at cycles 21 and 101 respectively; bit widths exact.
